// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake, FIFO write port and status counters of the
// four-producer FIFO write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [ID_W+DATA_W-1:0]  fifo_din;
    logic [ID_W-1:0]         grant_id;
    logic [31:0]             word_count;
    logic [31:0]             stall_count;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_id, word_count, stall_count
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_id, word_count, stall_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one {id,data} FIFO between four producers,
// with bounded ownership bursts and word/stall counters.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_100MHz,
    input  logic               reset_rtl_0,
    fifo_wr_arbiter_if.slave   arb
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]        burst_q, burst_d;
    logic [31:0]       word_q, stall_q;

    logic [ID_W-1:0]   scan_base, scan_idx, scan_win, winner;
    logic              scan_hit, hold_valid, have_winner, xfer;
    logic [DATA_W-1:0] data_sel;
    logic [N_REQ-1:0]  ready_w;
    logic              out_en;

    // A released owner hands the scan start to its successor in the same cycle.
    always_comb begin
        hold_valid = (state_q == HOLD) && arb.req_valid[owner_q];
        scan_base  = (state_q == HOLD) ? owner_q + ID_W'(1) : rr_ptr_q;
        scan_hit   = 1'b0;
        scan_win   = scan_base;
        scan_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = scan_base + ID_W'(k);
            if (!scan_hit && arb.req_valid[scan_idx]) begin
                scan_hit = 1'b1;
                scan_win = scan_idx;
            end
        end
        winner      = hold_valid ? owner_q : scan_win;
        have_winner = hold_valid | scan_hit;
        xfer        = have_winner & ~arb.fifo_full;
        data_sel    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner) data_sel = arb.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Outputs are forced low while reset is held, independent of any clock edge.
    always_comb begin
        out_en  = ~reset_rtl_0;
        ready_w = '0;
        if (xfer && out_en) ready_w[winner] = 1'b1;
    end

    assign arb.req_ready   = ready_w;
    assign arb.fifo_wr_en  = xfer & out_en;
    assign arb.fifo_din    = (have_winner && out_en) ? {winner, data_sel} : '0;
    assign arb.grant_id    = (have_winner && out_en) ? winner : '0;
    assign arb.word_count  = word_q;
    assign arb.stall_count = stall_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        if (xfer) begin
            if (hold_valid) begin
                if (burst_q + 4'd1 == BURST_LAST) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + ID_W'(1);
                    burst_d  = '0;
                end else begin
                    burst_d = burst_q + 4'd1;
                end
            end else begin
                owner_d = winner;
                burst_d = 4'd1;
                if (BURST_LAST == 4'd1) begin
                    state_d  = IDLE;
                    rr_ptr_d = winner + ID_W'(1);
                end else begin
                    state_d = HOLD;
                end
            end
        end else if (state_q == HOLD && !hold_valid) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q + ID_W'(1);
            burst_d  = '0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            word_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            word_q   <= word_q + 32'(xfer);
            if ((|arb.req_valid) && arb.fifo_full) stall_q <= stall_q + 32'd1;
        end
    end
endmodule
